// File: rtl/aes_pkg.sv
// Shared AES InvMixColumns constants, FSM encoding and GF(2^8) helpers.
// The optional forward-mode feature in the top is enabled by defining INVMIX_FWD_MODE_EN.
package aes_pkg;

  localparam logic [7:0] INV_MIX_K0 = 8'h0e;
  localparam logic [7:0] INV_MIX_K1 = 8'h0b;
  localparam logic [7:0] INV_MIX_K2 = 8'h0d;
  localparam logic [7:0] INV_MIX_K3 = 8'h09;

  localparam logic [7:0] FWD_MIX_K0 = 8'h02;
  localparam logic [7:0] FWD_MIX_K1 = 8'h03;
  localparam logic [7:0] FWD_MIX_K2 = 8'h01;
  localparam logic [7:0] FWD_MIX_K3 = 8'h01;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Coefficient applied to input row j when producing output row `row`:
  // the base vector rotated right by the output row index.
  function automatic logic [3:0] mixConst(input logic [1:0] row, input logic [1:0] j,
                                          input logic fwd);
    logic [1:0] idx;
    logic [3:0] k;
    idx = j - row;
    k   = 4'h0;
    case (idx)
      2'd0:    k = fwd ? FWD_MIX_K0[3:0] : INV_MIX_K0[3:0];
      2'd1:    k = fwd ? FWD_MIX_K1[3:0] : INV_MIX_K1[3:0];
      2'd2:    k = fwd ? FWD_MIX_K2[3:0] : INV_MIX_K2[3:0];
      default: k = fwd ? FWD_MIX_K3[3:0] : INV_MIX_K3[3:0];
    endcase
    return k;
  endfunction

endpackage

// File: rtl/inv_mixcolumn_module_gf_mul.sv
// Combinational GF(2^8) multiply of a byte by a 4-bit constant (mod 0x11b).
module gf_mul_const
  import aes_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [3:0] i_const,
  output logic [7:0] o_product
);

  logic [7:0] w_x1;
  logic [7:0] w_x2;
  logic [7:0] w_x3;

  // xtime chain gives data*2, data*4, data*8; each set constant bit selects one term.
  assign w_x1 = xtime(i_data);
  assign w_x2 = xtime(w_x1);
  assign w_x3 = xtime(w_x2);

  assign o_product = ({8{i_const[0]}} & i_data) ^
                     ({8{i_const[1]}} & w_x1)   ^
                     ({8{i_const[2]}} & w_x2)   ^
                     ({8{i_const[3]}} & w_x3);

endmodule

// File: rtl/inv_mixcolumn_module.sv
// Sequential AES InvMixColumns: one result byte per cycle over 16 cycles, then a done pulse.
// Define INVMIX_FWD_MODE_EN to add a 'mode' input selecting forward MixColumns constants.
module inv_mixcolumn_module
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef INVMIX_FWD_MODE_EN
  input  logic        mode,
`endif
  input  logic [31:0] statew1,
  input  logic [31:0] statew2,
  input  logic [31:0] statew3,
  input  logic [31:0] statew4,
  output logic        busy,
  output logic        done,
  output logic [31:0] new_statew1,
  output logic [31:0] new_statew2,
  output logic [31:0] new_statew3,
  output logic [31:0] new_statew4
);

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic [31:0] r_colReg   [4];
  logic [31:0] r_newState [4];
  logic        w_fwd;
  logic [1:0]  w_row;
  logic [1:0]  w_col;
  logic [31:0] w_column;
  logic [7:0]  w_s    [4];
  logic [7:0]  w_prod [4];
  logic [7:0]  w_resultByte;

`ifdef INVMIX_FWD_MODE_EN
  logic r_mode;
  assign w_fwd = r_mode;
`else
  assign w_fwd = 1'b0;
`endif

  assign w_row    = r_count[3:2];
  assign w_col    = r_count[1:0];
  assign w_column = r_colReg[w_col];

  for (genvar g = 0; g < 4; g++) begin : g_mul
    assign w_s[g] = w_column[31 - 8*g -: 8];
    gf_mul_const u_mul (
      .i_data    (w_s[g]),
      .i_const   (mixConst(w_row, 2'(g), w_fwd)),
      .o_product (w_prod[g])
    );
  end

  assign w_resultByte = w_prod[0] ^ w_prod[1] ^ w_prod[2] ^ w_prod[3];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (start) w_nextState = ST_CALC;
      ST_CALC: if (r_count == 4'd15) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Count wraps naturally from 15 to 0 on the final CALC write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_colReg[i]   <= 32'd0;
        r_newState[i] <= 32'd0;
      end
`ifdef INVMIX_FWD_MODE_EN
      r_mode <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_colReg[0] <= statew1;
            r_colReg[1] <= statew2;
            r_colReg[2] <= statew3;
            r_colReg[3] <= statew4;
            r_count     <= 4'd0;
`ifdef INVMIX_FWD_MODE_EN
            r_mode      <= mode;
`endif
          end
        end
        ST_CALC: begin
          case (w_row)
            2'd0:    r_newState[w_col][31:24] <= w_resultByte;
            2'd1:    r_newState[w_col][23:16] <= w_resultByte;
            2'd2:    r_newState[w_col][15:8]  <= w_resultByte;
            default: r_newState[w_col][7:0]   <= w_resultByte;
          endcase
          r_count <= r_count + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign new_statew1 = r_newState[0];
  assign new_statew2 = r_newState[1];
  assign new_statew3 = r_newState[2];
  assign new_statew4 = r_newState[3];

endmodule

// File: tb/tb_inv_mixcolumn_module.sv
// Directed self-checking bench for inv_mixcolumn_module with hand-computed AES vectors.
// The mode-port steps are built only when INVMIX_FWD_MODE_EN is defined.
module tb_inv_mixcolumn_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] statew1, statew2, statew3, statew4;
  logic        busy, done;
  logic [31:0] new_statew1, new_statew2, new_statew3, new_statew4;

  int checks   = 0;
  int failures = 0;
  int lat;
  int doneSeen;

  inv_mixcolumn_module dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef INVMIX_FWD_MODE_EN
    .mode        (mode),
`endif
    .statew1     (statew1),
    .statew2     (statew2),
    .statew3     (statew3),
    .statew4     (statew4),
    .busy        (busy),
    .done        (done),
    .new_statew1 (new_statew1),
    .new_statew2 (new_statew2),
    .new_statew3 (new_statew3),
    .new_statew4 (new_statew4)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3, input logic [31:0] e4);
    checkOutput({tag, "_w1"}, new_statew1, e1);
    checkOutput({tag, "_w2"}, new_statew2, e2);
    checkOutput({tag, "_w3"}, new_statew3, e3);
    checkOutput({tag, "_w4"}, new_statew4, e4);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
    statew1 = a;
    statew2 = b;
    statew3 = c;
    statew4 = d;
  endtask

  // Pulse start for one accepting edge, then return edges-after-acceptance until done (-1 on timeout).
  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, output int latency);
    applyStimulus(a, b, c, d);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(32'hdeadbeef, 32'h12345678, 32'hffffffff, 32'h0badf00d);
    latency = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        latency = i;
        break;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0);

    // Reset state
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkAll("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    rst = 1'b0;
    tick();

    // Basic vector, latency and done width
    runOp(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, lat);
    checkOutput("basic_latency", lat, 32'd16);
    checkOutput("basic_busy_at_done", {31'd0, busy}, 32'd1);
    checkAll("basic", 32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    tick();
    checkOutput("basic_done_width", {31'd0, done}, 32'd0);
    checkOutput("basic_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("basic_hold_w1", new_statew1, 32'hdb135345);

    // Held start: one done every 18 cycles, input changes during CALC ignored
    applyStimulus(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8);
    start = 1'b1;
    tick();
    checkOutput("held_busy_after_accept", {31'd0, busy}, 32'd1);
    applyStimulus(32'hffffffff, 32'h00000000, 32'ha5a5a5a5, 32'h5a5a5a5a);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    checkOutput("held_first_latency", lat, 32'd16);
    checkAll("held_first", 32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
    applyStimulus(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 3) applyStimulus(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      if (done) begin
        lat = i;
        break;
      end
    end
    checkOutput("held_period", lat, 32'd18);
    checkAll("held_second", 32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
    start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("held_stop_busy", {31'd0, busy}, 32'd0);

    // Reset mid-operation at count 7, then a clean rerun
    applyStimulus(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkAll("midrst", 32'd0, 32'd0, 32'd0, 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) doneSeen = 1;
    end
    checkOutput("midrst_no_done", doneSeen, 32'd0);
    runOp(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, lat);
    checkOutput("midrst_rerun_latency", lat, 32'd16);
    checkAll("midrst_rerun", 32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    tick();

    // Boundary vectors
    runOp(32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, lat);
    checkOutput("bound_d5_latency", lat, 32'd16);
    checkAll("bound_d5", 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5);
    tick();
    runOp(32'd0, 32'd0, 32'd0, 32'd0, lat);
    checkOutput("bound_zero_latency", lat, 32'd16);
    checkAll("bound_zero", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

`ifdef INVMIX_FWD_MODE_EN
    // Forward mode and round trip back through inverse mode
    mode = 1'b1;
    runOp(32'hdb135345, 32'd0, 32'd0, 32'd0, lat);
    mode = 1'b0;
    checkOutput("fwd_latency", lat, 32'd16);
    checkOutput("fwd_w1", new_statew1, 32'h8e4da1bc);
    tick();
    runOp(32'h8e4da1bc, 32'd0, 32'd0, 32'd0, lat);
    checkOutput("fwd_roundtrip_w1", new_statew1, 32'hdb135345);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
